y86_fetch_queue: RTL and testbench

- Sequential successor to the combinational instruction memory decoder.
- Fetches Y86 instruction bytes one per beat from a byte memory port and assembles variable-length instructions.
- Pushes decoded fields (icode, ifun, rA, rB, valC, valP, pc) into a prefetch queue drained by decode through a valid/ready handshake.
- Supports redirect/flush from execute (jump, call, ret) and stops fetching on halt or an invalid opcode.

---
 rtl/y86_fetch_queue_pkg.sv | 42 ++++
 rtl/y86_fetch_fifo.sv | 49 ++++
 rtl/y86_fetch_queue.sv | 135 +++++++++++++
 tb/tb_y86_fetch_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_fetch_queue_pkg.sv
// y86_fetch_queue_pkg: shared constants for the Y86 fetch queue.
//   DEF_DATA_WID  default address/constant width
//   I_HALT..I_POPQ icode values, REG_NONE absent-register code
//   state_t       fetch FSM states
//   instr_len     instruction length in bytes from icode (invalid -> 1)
package y86_fetch_queue_pkg;
    localparam int DEF_DATA_WID = 32;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_OPC, S_REG, S_VALC, S_PUSH, S_HALT} state_t;

    function automatic logic is_valid(input logic [3:0] ic);
        return ic <= I_POPQ;
    endfunction

    // jXX/call carry valC directly after the opcode byte (no register byte)
    function automatic logic valc_first(input logic [3:0] ic);
        return ic == I_JXX || ic == I_CALL;
    endfunction

    function automatic logic [3:0] instr_len(input logic [3:0] ic, input int vb);
        case (ic)
            I_HALT, I_NOP, I_RET:              return 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  return 4'd2;
            I_JXX, I_CALL:                     return 4'(1 + vb);
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      return 4'(2 + vb);
            default:                           return 4'd1;
        endcase
    endfunction
endpackage

// File: rtl/y86_fetch_fifo.sv
// y86_fetch_fifo: DEPTH x WID synchronous FIFO with flush.
//   flush        empties the FIFO (wins over push/pop)
//   push/wdata   write; accepted when not full, or when full with a pop
//   pop/rdata    rdata shows the head; pop ignored when empty
//   full/empty   occupancy flags
module y86_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WID   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] wdata,
    output logic [WID-1:0] rdata,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WID-1:0] mem [DEPTH];
    logic [AW:0]    wp, rp;
    logic           do_push, do_pop;

    // extra pointer bit tells full from empty when the indices match
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue: byte-serial Y86 fetch unit feeding a decoded-instruction queue.
//   mem_req/mem_addr/mem_gnt   one-byte read request, held until granted
//   mem_rvalid/mem_rdata       in-order read data, one outstanding read max
//   redirect/redirect_pc       flush queue and restart fetch at redirect_pc
//   out_valid/out_ready        head handshake; out_* fields are 0 when empty
//   halted                     fetch stopped after a halt or invalid opcode
module y86_fetch_queue
    import y86_fetch_queue_pkg::*;
#(
    parameter int                  DATA_WID = DEF_DATA_WID,
    parameter int                  QDEPTH   = 4,
    parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [DATA_WID-1:0] mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [7:0]          mem_rdata,
    input  logic                redirect,
    input  logic [DATA_WID-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_icode,
    output logic [3:0]          out_ifun,
    output logic [3:0]          out_rA,
    output logic [3:0]          out_rB,
    output logic [DATA_WID-1:0] out_valC,
    output logic [DATA_WID-1:0] out_valP,
    output logic [DATA_WID-1:0] out_pc,
    output logic                out_err,
    output logic                halted
);
    localparam int VALC_BYTES = DATA_WID / 8;
    localparam int EW         = 17 + 3 * DATA_WID;
    localparam int VW         = $clog2(DATA_WID);

    state_t              state, state_nxt;
    logic [DATA_WID-1:0] pc, valc, valp;
    logic [3:0]          icode, ifun, ra, rb, len, len_b0, k, idx;
    logic [VW-1:0]       vbase;
    logic                outs, stale, byte_ok, push, pop, full, empty, stop;
    logic [EW-1:0]       head;

    // a byte returning for a read issued before a redirect is stale
    assign byte_ok   = mem_rvalid && !stale;
    assign mem_req   = (state == S_OPC || state == S_REG || state == S_VALC) && !outs;
    assign mem_addr  = pc + DATA_WID'(k);
    assign valp      = pc + DATA_WID'(len);
    assign len_b0    = instr_len(mem_rdata[7:4], VALC_BYTES);
    assign stop      = icode == I_HALT || !is_valid(icode);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = state == S_PUSH && (!full || pop) && !redirect;
    assign halted    = state == S_HALT;
    assign idx       = k - (valc_first(icode) ? 4'd1 : 4'd2);
    assign vbase     = VW'({idx, 3'b000});

    y86_fetch_fifo #(.DEPTH(QDEPTH), .WID(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({!is_valid(icode), icode, ifun, ra, rb, valc, valp, pc}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign {out_err, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_pc} =
        out_valid ? head : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = full ? S_IDLE : S_OPC;
            S_OPC:  if (byte_ok) state_nxt = len_b0 == 4'd1 ? S_PUSH :
                                             valc_first(mem_rdata[7:4]) ? S_VALC : S_REG;
            S_REG:  if (byte_ok) state_nxt = len == 4'd2 ? S_PUSH : S_VALC;
            S_VALC: if (byte_ok && k == len - 4'd1) state_nxt = S_PUSH;
            S_PUSH: if (push) state_nxt = stop ? S_HALT : S_IDLE;
            default: state_nxt = state;
        endcase
        if (redirect) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            k     <= '0;
            len   <= '0;
            icode <= '0;
            ifun  <= '0;
            ra    <= REG_NONE;
            rb    <= REG_NONE;
            valc  <= '0;
            outs  <= 1'b0;
            stale <= 1'b0;
        end else begin
            outs  <= (outs && !mem_rvalid) || (mem_req && mem_gnt);
            // on redirect, whatever read is still in flight becomes stale
            stale <= redirect ? (outs && !mem_rvalid) || (mem_req && mem_gnt)
                              : stale && !mem_rvalid;
            if (redirect) begin
                pc <= redirect_pc;
                k  <= '0;
            end else begin
                if (state == S_IDLE) k <= '0;
                if (push) pc <= valp;
                if (byte_ok) begin
                    k <= k + 4'd1;
                    case (state)
                        S_OPC: begin
                            {icode, ifun} <= mem_rdata;
                            ra            <= REG_NONE;
                            rb            <= REG_NONE;
                            valc          <= '0;
                            len           <= len_b0;
                        end
                        S_REG:   {ra, rb} <= mem_rdata;
                        S_VALC:  valc[vbase +: 8] <= mem_rdata;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_y86_fetch_queue.sv
// tb_y86_fetch_queue: directed and randomized checks of y86_fetch_queue against
// an instruction-walking reference model over a sparse byte memory.
module tb_y86_fetch_queue;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        redirect, out_valid, out_ready, out_err, halted;
    logic [31:0] redirect_pc, out_valC, out_valP, out_pc;
    logic [3:0]  out_icode, out_ifun, out_rA, out_rB;

    always #5 clk = ~clk;

    y86_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
        .out_valC(out_valC), .out_valP(out_valP), .out_pc(out_pc),
        .out_err(out_err), .halted(halted)
    );

    typedef struct packed {
        logic        err;
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] valc, valp, pc;
    } ent_t;

    int          checks = 0, failures = 0;
    logic [7:0]  mem [logic [31:0]];
    ent_t        got [$];
    int          gnt_pct = 100, lat_lo = 0, lat_hi = 0, gnt_cnt = 0;
    logic        rand_rdy = 1'b0;
    logic        pend = 1'b0, hold = 1'b0;
    int          dly = 0;
    logic [31:0] paddr = '0, haddr = '0;
    logic [31:0] mpc = '0;
    logic        mhalted = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Decode straight from the memory image: what decode must see at pc.
    function automatic ent_t model(input logic [31:0] pc);
        ent_t       e;
        logic [7:0] b;
        int         len;
        b = rd(pc);
        e = '0;
        e.pc = pc;
        {e.icode, e.ifun} = b;
        e.ra = 4'hF;
        e.rb = 4'hF;
        case (e.icode)
            4'h0, 4'h1, 4'h9: len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len = 2;
                {e.ra, e.rb} = rd(pc + 32'd1);
            end
            4'h7, 4'h8: begin
                len = 5;
                e.valc = {rd(pc + 32'd4), rd(pc + 32'd3), rd(pc + 32'd2), rd(pc + 32'd1)};
            end
            4'h3, 4'h4, 4'h5: begin
                len = 6;
                {e.ra, e.rb} = rd(pc + 32'd1);
                e.valc = {rd(pc + 32'd5), rd(pc + 32'd4), rd(pc + 32'd3), rd(pc + 32'd2)};
            end
            default: begin
                len = 1;
                e.err = 1'b1;
            end
        endcase
        e.valp = pc + 32'(len);
        return e;
    endfunction

    task automatic put(input logic [31:0] a, input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) mem[a + 32'(i)] = bytes[8 * (n - 1 - i) +: 8];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_halted", halted, 0);
        tick;
        gnt_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        tick;
        redirect = 1'b0;
        chk("redir_empty", out_valid, 0);
        chk("redir_halted", halted, 0);
    endtask

    task automatic wait_done;
        int n = 0;
        while (!(halted && !out_valid) && n < 3000) begin
            tick;
            n++;
        end
        chk("done_in_time", n < 3000, 1);
    endtask

    // Memory responder: random grant, 1+ cycle in-order latency, one read at a time.
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                hold = 1'b0;
            end else if (pend) begin
                chk("one_outstanding", mem_req, 0);
                if (dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd(paddr);
                    pend = 1'b0;
                end else dly--;
            end else if (mem_req) begin
                if (hold) chk("addr_stable", mem_addr, haddr);
                if (int'($urandom_range(1, 100)) <= gnt_pct) begin
                    mem_gnt = 1'b1;
                    pend = 1'b1;
                    paddr = mem_addr;
                    dly = int'($urandom_range(lat_lo, lat_hi));
                    gnt_cnt++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    haddr = mem_addr;
                end
            end else hold = 1'b0;
        end
    end

    // Scoreboard: every accepted head must be the next instruction of the walk.
    initial begin
        ent_t obs, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mpc = 32'h0;
                mhalted = 1'b0;
            end else if (redirect) begin
                mpc = redirect_pc;
                mhalted = 1'b0;
            end else if (out_valid && out_ready) begin
                obs = {out_err, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_pc};
                chk("pop_after_halt", mhalted, 0);
                e = model(mpc);
                chk("entry", obs, e);
                got.push_back(obs);
                mpc = e.valp;
                if (e.icode == 4'h0 || e.err) mhalted = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc [4];
        logic [31:0] exp_vp [4];
        int          n;
        exp_pc = '{32'd0, 32'd1, 32'd3, 32'd4};
        exp_vp = '{32'd1, 32'd3, 32'd4, 32'd5};
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        #1;
        chk("rst_valid0", out_valid, 0);
        chk("rst_req0", mem_req, 0);
        chk("rst_halted0", halted, 0);
        chk("rst_icode0", out_icode, 0);
        chk("rst_rA0", out_rA, 0);
        chk("rst_valC0", out_valC, 0);
        chk("rst_pc0", out_pc, 0);

        // irmovq $10, %rdx then halt
        put(32'h0, 64'h30F20A000000, 6);
        out_ready = 1'b1;
        got.delete();
        tick;
        rst_n = 1'b1;
        wait_done;
        chk("t1_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("t1_icode", got[0].icode, 4'h3);
            chk("t1_ifun", got[0].ifun, 4'h0);
            chk("t1_rA", got[0].ra, 4'hF);
            chk("t1_rB", got[0].rb, 4'h2);
            chk("t1_valC", got[0].valc, 32'hA);
            chk("t1_pc", got[0].pc, 32'h0);
            chk("t1_valP", got[0].valp, 32'h6);
            chk("t1_halt", got[1].icode, 4'h0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t1_halted", halted, 1);
            chk("t1_noreq", mem_req, 0);
            tick;
        end

        // nop; addq; ret; halt
        mem.delete();
        put(32'h0, 64'h1060239000, 5);
        got.delete();
        do_reset;
        wait_done;
        chk("t2_count", got.size(), 4);
        if (got.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_pc", got[i].pc, exp_pc[i]);
                chk("t2_valP", got[i].valp, exp_vp[i]);
            end
            chk("t2_last_halt", got[3].icode, 4'h0);
        end
        chk("t2_halted", halted, 1);

        // backpressure: queue fills to QDEPTH and fetch stops
        mem.delete();
        for (int a = 0; a < 64; a++) mem[32'(a)] = 8'h10;
        out_ready = 1'b0;
        got.delete();
        do_reset;
        repeat (40) tick;
        chk("t3_grants", gnt_cnt, 4);
        chk("t3_noreq", mem_req, 0);
        chk("t3_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done;
        chk("t3_count", got.size(), 65);
        if (got.size() == 65) begin
            chk("t3_order", got[3].pc, 32'h3);
            chk("t3_halt_pc", got[64].pc, 32'h40);
        end

        // redirect while irmovq is half assembled with a read outstanding
        mem.delete();
        put(32'h0, 64'h1030F20A00000000, 8);
        put(32'h40, 64'h1000, 2);
        out_ready = 1'b0;
        lat_lo = 4;
        lat_hi = 4;
        got.delete();
        do_reset;
        n = 0;
        while (!(pend && paddr == 32'h3) && n < 200) begin
            tick;
            n++;
        end
        chk("t4_reached", n < 200, 1);
        chk("t4_nop_queued", out_valid, 1);
        do_redirect(32'h40);
        lat_lo = 0;
        lat_hi = 0;
        out_ready = 1'b1;
        wait_done;
        chk("t4_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("t4_pc", got[0].pc, 32'h40);
            chk("t4_icode", got[0].icode, 4'h1);
            chk("t4_halt_pc", got[1].pc, 32'h41);
        end

        // invalid opcode
        put(32'h10, 64'hC5, 1);
        got.delete();
        do_redirect(32'h10);
        wait_done;
        chk("t5_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t5_err", got[0].err, 1);
            chk("t5_icode", got[0].icode, 4'hC);
            chk("t5_ifun", got[0].ifun, 4'h5);
            chk("t5_valP", got[0].valp, 32'h11);
            chk("t5_rA", got[0].ra, 4'hF);
        end
        chk("t5_halted", halted, 1);
        do_redirect(32'h40);
        wait_done;

        // jXX at the top of the address space: valP wraps
        put(32'hFFFFFFFC, 64'h7011223344, 5);
        mem[32'h1] = 8'h00;
        got.delete();
        do_redirect(32'hFFFFFFFC);
        wait_done;
        chk("t6_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("t6_icode", got[0].icode, 4'h7);
            chk("t6_valC", got[0].valc, 32'h44332211);
            chk("t6_valP", got[0].valp, 32'h1);
            chk("t6_next_pc", got[1].pc, 32'h1);
        end

        // random programs, random grant/latency/ready, random redirects, one reset
        mem.delete();
        for (int a = 0; a < 256; a++) mem[32'(a)] = 8'($urandom);
        rand_rdy = 1'b1;
        for (int r = 0; r < 25; r++) begin
            gnt_pct = int'($urandom_range(30, 100));
            lat_lo = 0;
            lat_hi = int'($urandom_range(0, 3));
            if (r == 10) do_reset;
            else do_redirect($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 15)) tick;
                if (r == 17) begin
                    rst_n = 1'b0;
                    tick;
                    rst_n = 1'b1;
                end else do_redirect($urandom_range(0, 255));
            end
            wait_done;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
